mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_rr_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and index helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int NUM_CH_DEF       = 2;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int ADDR_WIDTH_DEF   = 12;
  localparam int READ_LATENCY_DEF = 1;
  localparam int CNT_WIDTH_DEF    = 16;

  // Channel index width; a single channel still needs one bit to carry an index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = idx_width(NUM_CH_DEF);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after start, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(start) + i) % N]) begin
        any                         = 1'b1;
        gnt[(int'(start) + i) % N]  = 1'b1;
        idx                         = IW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel round-robin arbiter in front of a single-port memory with
// grant locking, a read-return tag pipeline and saturating per-channel grant counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0]              ch_lock,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]              ch_gnt,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [DATA_WIDTH-1:0]          ch_rdata,
  output logic                           mem_enable,
  output logic                           mem_read_enable,
  output logic                           mem_write_enable,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]          mem_data,
  input  logic [DATA_WIDTH-1:0]          mem_from_data,
  output logic [NUM_CH*CNT_WIDTH-1:0]    gnt_count
);

  localparam int IW = idx_width(NUM_CH);

  // Handshake: a channel holds ch_req with stable write/addr/wdata; the access is
  // taken in exactly the cycle its ch_gnt is high. Read data returns READ_LATENCY
  // cycles later as a single-cycle ch_rvalid pulse with no back-pressure.

  logic [NUM_CH-1:0]                   req_eff;
  logic [IW-1:0]                       last_q;
  logic [IW-1:0]                       start;
  logic                                lock_v_q;
  logic [IW-1:0]                       lock_idx_q;
  logic                                use_lock;
  logic [NUM_CH-1:0]                   pick_gnt;
  logic [IW-1:0]                       pick_idx;
  logic                                pick_any;
  logic [IW-1:0]                       gnt_idx;
  logic                                granted;
  logic [READ_LATENCY-1:0]             tag_v_q;
  logic [READ_LATENCY-1:0][IW-1:0]     tag_idx_q;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    cnt_q;

  assign req_eff = reset ? '0 : ch_req;
  assign start   = (last_q == IW'(NUM_CH - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .req   (req_eff),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A held lock overrides rotation until its owner drops the request.
  always_comb begin
    use_lock         = lock_v_q && req_eff[lock_idx_q];
    ch_gnt           = '0;
    gnt_idx          = '0;
    granted          = 1'b0;
    if (use_lock) begin
      ch_gnt[lock_idx_q] = 1'b1;
      gnt_idx            = lock_idx_q;
      granted            = 1'b1;
    end else if (pick_any) begin
      ch_gnt  = pick_gnt;
      gnt_idx = pick_idx;
      granted = 1'b1;
    end
    mem_enable       = granted;
    mem_read_enable  = granted && !ch_write[gnt_idx];
    mem_write_enable = granted && ch_write[gnt_idx];
    mem_address      = granted ? ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_data         = granted ? ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    ch_rvalid = '0;
    if (!reset && tag_v_q[READ_LATENCY-1]) begin
      ch_rvalid[tag_idx_q[READ_LATENCY-1]] = 1'b1;
    end
    ch_rdata = (|ch_rvalid) ? mem_from_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q     <= IW'(NUM_CH - 1);
      lock_v_q   <= 1'b0;
      lock_idx_q <= '0;
      tag_v_q    <= '0;
      tag_idx_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (granted) begin
        last_q     <= gnt_idx;
        lock_v_q   <= ch_lock[gnt_idx];
        lock_idx_q <= gnt_idx;
      end else begin
        lock_v_q   <= 1'b0;
      end
      tag_v_q[0]   <= mem_read_enable;
      tag_idx_q[0] <= gnt_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_gnt[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign gnt_count = cnt_q;

endmodule
